// File: rtl/seq_divider.sv
// Radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Fixed 34-cycle latency from accepted start to the done pulse.
module seq_divider (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] rem;
    logic [31:0] quo;
    logic [31:0] dvs;
    logic [5:0]  cnt;
    logic        is_rem;
    logic        neg_q;
    logic        neg_r;

    logic        signed_op;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [32:0] shl;
    logic [33:0] sub;
    logic [32:0] rem_nxt;
    logic [31:0] q_fix;
    logic [31:0] r_fix;
    logic        unused_msb;

    assign signed_op = ~op[0];
    assign a_mag     = (signed_op && a[31]) ? -a : a;
    assign b_mag     = (signed_op && b[31]) ? -b : b;

    // One restoring step: borrow out of the subtract means keep the old value
    assign shl        = {rem, quo[31]};
    assign sub        = {1'b0, shl} - {2'b00, dvs};
    assign rem_nxt    = sub[33] ? shl : sub[32:0];
    assign unused_msb = rem_nxt[32];

    assign q_fix = neg_q ? -quo : quo;
    assign r_fix = neg_r ? -rem : rem;

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = CALC;
            CALC:    if (cnt == 6'd31) state_nxt = FIX;
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rem    <= '0;
            quo    <= '0;
            dvs    <= '0;
            cnt    <= '0;
            is_rem <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            done   <= 1'b0;
            result <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        rem    <= '0;
                        quo    <= a_mag;
                        dvs    <= b_mag;
                        cnt    <= '0;
                        is_rem <= op[1];
                        // Divide by zero keeps the all-ones quotient unsigned
                        neg_q  <= signed_op && (a[31] ^ b[31]) && (b != '0);
                        neg_r  <= signed_op && a[31];
                    end
                end
                CALC: begin
                    rem <= rem_nxt[31:0];
                    quo <= {quo[30:0], ~sub[33]};
                    cnt <= cnt + 6'd1;
                end
                FIX: begin
                    result <= is_rem ? r_fix : q_fix;
                    done   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Randomised bench for seq_divider against an arithmetic RV32M model.
// Also covers the corner operands, start-while-busy and mid-op reset.
module tb_seq_divider;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;

    seq_divider dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [1:0] o,
                                          input logic [31:0] x,
                                          input logic [31:0] y);
        int sx;
        int sy;
        sx = x;
        sy = y;
        case (o)
            2'd0: begin
                if (y == 0) return 32'hFFFF_FFFF;
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return x;
                return sx / sy;
            end
            2'd1: return (y == 0) ? 32'hFFFF_FFFF : x / y;
            2'd2: begin
                if (y == 0) return x;
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 0;
                return sx % sy;
            end
            default: return (y == 0) ? x : x % y;
        endcase
    endfunction

    function automatic logic [31:0] rnd_operand();
        logic [31:0] v;
        case ($urandom_range(0, 7))
            0: v = 32'h0;
            1: v = 32'hFFFF_FFFF;
            2: v = 32'h8000_0000;
            3: v = $urandom_range(0, 15);
            4: v = -$urandom_range(1, 15);
            5: v = $urandom >> $urandom_range(0, 31);
            default: v = $urandom;
        endcase
        return v;
    endfunction

    // Present a request for the next edge (t0); scramble inputs after it
    task automatic launch(input logic [1:0] o, input logic [31:0] x,
                          input logic [31:0] y);
        op = o;
        a = x;
        b = y;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        op = 2'($urandom);
        a = $urandom;
        b = $urandom;
    endtask

    // lat counts edges from t0 inclusive up to the one that raised done
    task automatic wait_done(input int p1, input int p2,
                             output logic [31:0] r, output int lat,
                             output int busy_bad);
        lat = 1;
        busy_bad = 0;
        while (!done && lat < 60) begin
            if (!busy) busy_bad++;
            start = (lat == p1 || lat == p2);
            @(posedge clk);
            #1;
            start = 1'b0;
            lat++;
        end
        if (busy) busy_bad++;
        r = result;
    endtask

    task automatic run_op(input string tag, input logic [1:0] o,
                          input logic [31:0] x, input logic [31:0] y,
                          input int p1, input int p2);
        logic [31:0] r;
        int lat;
        int bb;
        launch(o, x, y);
        wait_done(p1, p2, r, lat, bb);
        check({tag, "_result"}, r, model(o, x, y));
        check({tag, "_latency"}, lat, 34);
        check({tag, "_busy"}, bb, 0);
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        int          seen_done;
        int          seen_busy;

        rst = 1'b1;
        start = 1'b0;
        op = 2'd0;
        a = '0;
        b = '0;
        @(posedge clk);
        #1;
        start = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_result", result, 0);

        // First request is taken on the very first edge out of reset
        rst = 1'b0;
        run_op("divu_100_7", 2'd1, 32'd100, 32'd7, 0, 0);
        check("divu_100_7_val", result, 32'd14);
        run_op("remu_100_7", 2'd3, 32'd100, 32'd7, 0, 0);
        check("remu_100_7_val", result, 32'd2);
        run_op("div_m7_2", 2'd0, 32'hFFFF_FFF9, 32'd2, 0, 0);
        check("div_m7_2_val", result, 32'hFFFF_FFFD);
        run_op("rem_m7_2", 2'd2, 32'hFFFF_FFF9, 32'd2, 0, 0);
        check("rem_m7_2_val", result, 32'hFFFF_FFFF);
        run_op("div_by0", 2'd0, 32'h1234_5678, 32'd0, 0, 0);
        check("div_by0_val", result, 32'hFFFF_FFFF);
        run_op("remu_by0", 2'd3, 32'h1234_5678, 32'd0, 0, 0);
        check("remu_by0_val", result, 32'h1234_5678);
        run_op("div_ovf", 2'd0, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
        check("div_ovf_val", result, 32'h8000_0000);
        run_op("rem_ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
        check("rem_ovf_val", result, 32'h0);

        // Starts while busy must neither disturb nor queue
        run_op("busy_start", 2'd1, 32'd1000, 32'd3, 5, 20);
        seen_busy = 0;
        seen_done = 0;
        repeat (5) begin
            @(posedge clk);
            #1;
            seen_busy |= busy;
            seen_done |= done;
        end
        check("no_queue_busy", seen_busy, 0);
        check("no_queue_done", seen_done, 0);
        check("hold_result", result, 32'd333);

        launch(2'd1, 32'd99, 32'd5);
        repeat (9) @(posedge clk);
        #1;
        check("pre_abort_busy", busy, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        seen_busy = 0;
        seen_done = 0;
        repeat (40) begin
            seen_busy |= busy;
            seen_done |= done;
            @(posedge clk);
            #1;
        end
        check("abort_busy", seen_busy, 0);
        check("abort_done", seen_done, 0);
        check("abort_result", result, 0);

        for (int i = 0; i < 1000; i++) begin
            ra = rnd_operand();
            rb = rnd_operand();
            run_op("rand", 2'($urandom), ra, rb, 0, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
